// File: rtl/frequency_analyzer_pkg.sv
// Shared definitions for the frequency pattern generator: FSM state
// encoding and the tone half-period derivation.
package frequency_analyzer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN_F0 = 2'd1,
        GEN_F1 = 2'd2,
        DONE   = 2'd3
    } gen_state_t;

    // Clock cycles per half period of a tone (integer division).
    // Returns 0 for a zero tone so the caller can reject it at elaboration.
    function automatic int unsigned half_period_cycles(
        input int unsigned clock_hz,
        input int unsigned tone_hz
    );
        if (tone_hz == 0) begin
            return 0;
        end
        return clock_hz / (2 * tone_hz);
    endfunction

endpackage

// File: rtl/square_wave_generator.sv
// Square wave source: toggles its output every half_period cycles.
// restart (or reset) clears both the output and the half-period counter,
// so the first toggle lands half_period cycles after restart is released.
module square_wave_generator (
    input  logic        clock,
    input  logic        reset,
    input  logic        restart,
    input  logic [31:0] half_period,
    output logic        wave
);

    logic [31:0] count_reg;
    logic        wave_reg;

    // Half-period counter and output toggle.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            count_reg <= 32'd0;
            wave_reg  <= 1'b0;
        end else if (count_reg >= half_period - 32'd1) begin
            count_reg <= 32'd0;
            wave_reg  <= ~wave_reg;
        end else begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign wave = wave_reg;

endmodule

// File: rtl/frequency_pattern_generator.sv
// Frequency pattern generator: alternates between two square-wave tones
// for programmable durations, for a programmable number of pairs (or until
// stopped), then pulses done and raises a sticky irq.
module frequency_pattern_generator
    import frequency_analyzer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned FREQUENCY0      = 9000,
    parameter int unsigned FREQUENCY1      = 11000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] f0_time,
    input  logic [31:0] f1_time,
    input  logic [15:0] repeat_count,   // f0/f1 pairs to run; 0 = until stop
    input  logic        irq_ack,
    output logic        sample_data,
    output logic        active,
    output logic        phase,
    output logic        done,
    output logic        irq
);

    localparam logic [31:0] HALF0 = half_period_cycles(CLOCK_FREQUENCY, FREQUENCY0);
    localparam logic [31:0] HALF1 = half_period_cycles(CLOCK_FREQUENCY, FREQUENCY1);

    // A zero half period would leave a tone undefined; refuse to build.
    if (HALF0 == 32'd0 || HALF1 == 32'd0) begin : g_half_check
        $error("frequency_pattern_generator: tone half period evaluates to 0");
    end

    gen_state_t  state_reg, state_next;
    logic [31:0] timer_reg, timer_next;
    logic [31:0] f0_reg, f0_next;
    logic [31:0] f1_reg, f1_next;
    logic [15:0] pairs_reg, pairs_next;
    logic        irq_reg;
    logic        enter_gen;
    logic        pair_end;
    logic        wave_restart;
    logic [31:0] half_sel;
    logic        wave;

    // State, phase timer, pair counter and latched pattern settings.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            timer_reg <= 32'd0;
            f0_reg    <= 32'd0;
            f1_reg    <= 32'd0;
            pairs_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            f0_reg    <= f0_next;
            f1_reg    <= f1_next;
            pairs_reg <= pairs_next;
        end
    end

    // Next-state logic. Zero-length phases are skipped; a pairs_reg of 0
    // while generating means the pattern runs until stop.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        f0_next    = f0_reg;
        f1_next    = f1_reg;
        pairs_next = pairs_reg;
        enter_gen  = 1'b0;
        pair_end   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    f0_next    = f0_time;
                    f1_next    = f1_time;
                    pairs_next = repeat_count;
                    if (f0_time != 32'd0) begin
                        state_next = GEN_F0;
                        timer_next = f0_time;
                        enter_gen  = 1'b1;
                    end else if (f1_time != 32'd0) begin
                        state_next = GEN_F1;
                        timer_next = f1_time;
                        enter_gen  = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            GEN_F0: begin
                if (stop) begin
                    state_next = DONE;
                    timer_next = 32'd0;
                end else if (timer_reg <= 32'd1) begin
                    if (f1_reg != 32'd0) begin
                        state_next = GEN_F1;
                        timer_next = f1_reg;
                        enter_gen  = 1'b1;
                    end else begin
                        pair_end = 1'b1;
                    end
                end else begin
                    timer_next = timer_reg - 32'd1;
                end
            end
            GEN_F1: begin
                if (stop) begin
                    state_next = DONE;
                    timer_next = 32'd0;
                end else if (timer_reg <= 32'd1) begin
                    pair_end = 1'b1;
                end else begin
                    timer_next = timer_reg - 32'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // End of an f0/f1 pair: finish on the last counted pair, otherwise
        // start the next pair at its first non-empty phase.
        if (pair_end) begin
            if (pairs_reg == 16'd1) begin
                state_next = DONE;
                timer_next = 32'd0;
                pairs_next = 16'd0;
            end else begin
                if (pairs_reg != 16'd0) begin
                    pairs_next = pairs_reg - 16'd1;
                end
                if (f0_reg != 32'd0) begin
                    state_next = GEN_F0;
                    timer_next = f0_reg;
                end else begin
                    state_next = GEN_F1;
                    timer_next = f1_reg;
                end
                enter_gen = 1'b1;
            end
        end
    end

    // Sticky interrupt: a new completion wins over a coincident acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= (state_reg == DONE) | (irq_reg & ~irq_ack);
        end
    end

    // Hold the wave cleared outside generation and on every phase entry.
    assign wave_restart = enter_gen || !(state_next == GEN_F0 || state_next == GEN_F1);
    assign half_sel     = (state_reg == GEN_F1) ? HALF1 : HALF0;

    square_wave_generator u_square_wave_generator (
        .clock       (clock),
        .reset       (reset),
        .restart     (wave_restart),
        .half_period (half_sel),
        .wave        (wave)
    );

    assign sample_data = wave;
    assign active      = (state_reg == GEN_F0) || (state_reg == GEN_F1);
    assign phase       = (state_reg == GEN_F1);
    assign done        = (state_reg == DONE);
    assign irq         = irq_reg;

endmodule

// File: tb/tb_frequency_pattern_generator.sv
// Randomized scoreboard bench for frequency_pattern_generator.
// Tone parameters: 1000 Hz clock, 100 Hz and 250 Hz tones (half periods 5, 2).
module tb_frequency_pattern_generator;

    localparam int CLK_HZ = 1000;
    localparam int TONE0  = 100;
    localparam int TONE1  = 250;
    localparam int HALF0  = CLK_HZ / (2 * TONE0);
    localparam int HALF1  = CLK_HZ / (2 * TONE1);

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] f0_time;
    logic [31:0] f1_time;
    logic [15:0] repeat_count;
    logic        irq_ack;
    logic        sample_data;
    logic        active;
    logic        phase;
    logic        done;
    logic        irq;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          len;
        int unsigned h;
    } exp_t;

    exp_t        exp_q[$];
    int          mon_len;
    int unsigned mon_hash;

    frequency_pattern_generator #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .FREQUENCY0      (TONE0),
        .FREQUENCY1      (TONE1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .f0_time      (f0_time),
        .f1_time      (f1_time),
        .repeat_count (repeat_count),
        .irq_ack      (irq_ack),
        .sample_data  (sample_data),
        .active       (active),
        .phase        (phase),
        .done         (done),
        .irq          (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: the pattern as a list of cycles {done,active,phase,sample},
    // folded into a length and a hash. Cycle c of tone n shows (c/HALFn)%2.
    function automatic void model(input int f0, input int f1, input int rep,
                                  input int stop_at, output int len,
                                  output int unsigned h);
        int          n;
        bit          halted;
        int unsigned v;
        n = 0; halted = 0; len = 0; h = 0;
        if (f0 != 0 || f1 != 0) begin
            for (int p = 0; (rep == 0 || p < rep) && !halted && p < 10000; p++) begin
                for (int c = 0; c < f0 && !halted; c++) begin
                    v = 32'd4 + 32'((c / HALF0) % 2);
                    h = h * 32'd31 + v; len++;
                    if (n == stop_at) halted = 1;
                    n++;
                end
                for (int c = 0; c < f1 && !halted; c++) begin
                    v = 32'd6 + 32'((c / HALF1) % 2);
                    h = h * 32'd31 + v; len++;
                    if (n == stop_at) halted = 1;
                    n++;
                end
            end
        end
        h = h * 32'd31 + 32'd8;
        len++;
    endfunction

    // Monitor: record every active/done cycle; on done, pop and compare.
    always @(negedge clock) begin
        exp_t        e;
        int unsigned v;
        if (reset) begin
            mon_len  = 0;
            mon_hash = 0;
        end else if (active || done) begin
            v = {28'd0, done, active, phase, sample_data};
            mon_hash = mon_hash * 32'd31 + v;
            mon_len++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done actual=done_pulse required=no_done_pending");
                end else begin
                    e = exp_q.pop_front();
                    check("pattern_length", mon_len, e.len);
                    check("pattern_trace", mon_hash, e.h);
                end
                mon_len  = 0;
                mon_hash = 0;
            end
        end
    end

    task automatic run_txn(input int f0, input int f1, input int rep, input int stop_at,
                           input bit dup, input bit ack_with_done, input bit do_ack);
        exp_t e;
        bit   got;
        model(f0, f1, rep, stop_at, e.len, e.h);
        exp_q.push_back(e);
        f0_time = f0; f1_time = f1; repeat_count = 16'(rep);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // scramble inputs: the pattern must run on the latched values
        f0_time = $urandom; f1_time = $urandom; repeat_count = 16'($urandom);
        got = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            if (done) begin
                got = 1;
            end else begin
                stop  = (k == stop_at);
                start = (dup && k == 2);
                @(posedge clock); #1;
                stop  = 1'b0;
                start = 1'b0;
            end
        end
        check("done_within_budget", got, 1);
        if (got) begin
            irq_ack = ack_with_done;
            @(posedge clock); #1;
            irq_ack = 1'b0;
            check("irq_after_done", irq, 1);
            if (do_ack) begin
                irq_ack = 1'b1;
                @(posedge clock); #1;
                irq_ack = 1'b0;
                check("irq_after_ack", irq, 0);
            end
        end
        $display("[TB] txn f0=%0d f1=%0d rep=%0d stop_at=%0d dup=%0d ackd=%0d len=%0d",
                 f0, f1, rep, stop_at, dup, ack_with_done, e.len);
    endtask

    initial begin
        int  f0, f1, rep, sa;
        bit  got_f1;
        reset = 1'b1; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
        f0_time = 32'd0; f1_time = 32'd0; repeat_count = 16'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_sample_data", sample_data, 0);
        check("reset_active", active, 0);
        check("reset_phase", phase, 0);
        check("reset_done", done, 0);
        check("reset_irq", irq, 0);

        // directed patterns
        run_txn(20, 8, 1, -1, 0, 0, 1);
        run_txn(10, 10, 3, -1, 1, 1, 1);
        run_txn(10, 10, 0, 37, 0, 0, 1);
        run_txn(0, 6, 2, -1, 0, 0, 1);
        run_txn(0, 0, 1, -1, 0, 1, 1);
        run_txn(7, 0, 2, -1, 1, 0, 1);
        run_txn(10, 10, 1, 9, 0, 0, 1);

        // randomized patterns
        for (int i = 0; i < 30; i++) begin
            f0  = $urandom_range(0, 12);
            f1  = $urandom_range(0, 12);
            rep = $urandom_range(0, 3);
            if (rep == 0) sa = $urandom_range(0, 40);
            else if ($urandom_range(0, 3) == 0) sa = $urandom_range(0, 30);
            else sa = -1;
            run_txn(f0, f1, rep, sa, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b1);
        end

        // leave irq set, then reset in the middle of GEN_F1
        run_txn(0, 0, 1, -1, 0, 0, 0);
        f0_time = 32'd4; f1_time = 32'd50; repeat_count = 16'd1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        got_f1 = 0;
        for (int k = 0; k < 200 && !got_f1; k++) begin
            if (phase) got_f1 = 1;
            else begin @(posedge clock); #1; end
        end
        check("reached_gen_f1", got_f1, 1);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        check("midrun_reset_sample_data", sample_data, 0);
        check("midrun_reset_active", active, 0);
        check("midrun_reset_phase", phase, 0);
        check("midrun_reset_done", done, 0);
        check("midrun_reset_irq", irq, 0);
        reset = 1'b0;
        $display("[TB] txn reset during GEN_F1");

        // recovery after reset
        run_txn(6, 4, 2, -1, 0, 0, 1);

        repeat (3) @(posedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frequency_pattern_generator.md
FREQUENCY_PATTERN_GENERATOR -- requirements
Module: frequency_pattern_generator

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 100000000, clock rate in Hz.
REQ-002 SHALL have parameter FREQUENCY0, default 9000, first tone in Hz.
REQ-003 SHALL have parameter FREQUENCY1, default 11000, second tone in Hz.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins a pattern when idle.
REQ-007 SHALL have port stop  input  1  level; aborts an active pattern.
REQ-008 SHALL have port f0_time  input  32  clock cycles spent in tone 0 per pair.
REQ-009 SHALL have port f1_time  input  32  clock cycles spent in tone 1 per pair.
REQ-010 SHALL have port repeat  input  16  number of f0/f1 pairs; 0 = run until stop.
REQ-011 SHALL have port irq_ack  input  1  one-cycle pulse; clears irq.
REQ-012 SHALL have port sample_data  output  1  generated square wave, feeds the analyzer sample input.
REQ-013 SHALL have port active  output  1  high while in GEN_F0 or GEN_F1.
REQ-014 SHALL have port phase  output  1  0 in GEN_F0, 1 in GEN_F1, 0 otherwise.
REQ-015 SHALL have port done  output  1  one-cycle pulse on completion or abort.
REQ-016 SHALL have port irq  output  1  sticky completion flag.

Function
REQ-017 SHALL derive HALF0 = CLOCK_FREQUENCY/(2*FREQUENCY0) and HALF1 = CLOCK_FREQUENCY/(2*FREQUENCY1), integer division; elaboration SHALL fail if either is 0.
REQ-018 SHALL implement states IDLE, GEN_F0, GEN_F1, DONE.
REQ-019 In IDLE, start SHALL latch f0_time, f1_time, repeat and move to GEN_F0 next cycle; start outside IDLE SHALL be ignored.
REQ-020 On entry to any GEN state, sample_data SHALL be 0 and the half-period counter SHALL be 0.
REQ-021 In GEN_Fn, sample_data SHALL toggle every HALFn cycles (first toggle HALFn cycles after entry).
REQ-022 Phase timer SHALL load fn_time on entry and GEN_Fn SHALL last exactly fn_time cycles.
REQ-023 A phase with latched time 0 SHALL be skipped (zero cycles spent); both zero SHALL go IDLE -> DONE.
REQ-024 GEN_F1 exit SHALL decrement the pair counter; at 0 go DONE, else GEN_F0; repeat = 0 SHALL never terminate.
REQ-025 stop high in GEN_F0/GEN_F1 SHALL force DONE next cycle, overriding phase expiry in the same cycle.
REQ-026 DONE SHALL last one cycle, assert done, set irq, then return to IDLE; sample_data SHALL be 0 in IDLE and DONE.
REQ-027 irq SHALL stay high until irq_ack; irq_ack coincident with a new set SHALL leave irq set.
REQ-028 Timers SHALL be 32-bit; no wrap-around; counters SHALL saturate at 0, never underflow.

Reset
REQ-029 reset SHALL dominate all inputs and take effect on the next rising edge, including mid-pattern.
REQ-030 After reset: state IDLE, sample_data 0, active 0, phase 0, done 0, irq 0, all counters and latched values 0.

Structure
REQ-031 State encoding and the HALF computation function SHALL live in shared package frequency_analyzer_pkg.
REQ-032 Square-wave toggling SHALL be one sub-module, square_wave_generator (inputs: clock, reset, restart, half_period; output: wave), instantiated once with half_period muxed by phase.

Verification (CLOCK_FREQUENCY=1000, FREQUENCY0=100 -> HALF0=5, FREQUENCY1=250 -> HALF1=2)
REQ-033 f0_time=20, f1_time=8, repeat=1, start -> sample_data toggles at cycles 5,10,15 of GEN_F0, then at 2,4,6 of GEN_F1; done pulse after 28 active cycles; irq=1.
REQ-034 repeat=3, f0_time=10, f1_time=10 -> active high 60 cycles, phase sequence 0,1,0,1,0,1, exactly one done pulse.
REQ-035 repeat=0, f0_time=f1_time=10, stop at cycle 37 -> DONE next cycle, sample_data 0, done pulse, irq=1.
REQ-036 f0_time=0, f1_time=6, repeat=2 -> phase never 0 while active; active 12 cycles; f0_time=f1_time=0 -> done one cycle after start, active never high.
REQ-037 reset asserted mid GEN_F1 -> next cycle all outputs 0, state IDLE; start pulse during active pattern -> no restart.
REQ-038 irq_ack and done in same cycle -> irq remains 1; separate irq_ack -> irq 0 next cycle.
